// File: rtl/mem_access_stage_if.sv
// Data-memory request/grant/response bus between the MEM stage and the memory.
// The stage is the master: it drives the request and store payload. The memory
// returns a grant and, for loads, a read response.
interface mem_access_stage_if #(
    parameter int unsigned DATA_WIDTH = 32
);

    logic                      dm_req;
    logic                      dm_we;
    logic [DATA_WIDTH-1:0]     dm_addr;
    logic [DATA_WIDTH/8-1:0]   dm_wstrb;
    logic [DATA_WIDTH-1:0]     dm_wdata;
    logic                      dm_gnt;
    logic                      dm_rvalid;
    logic [DATA_WIDTH-1:0]     dm_rdata;

    modport master (
        output dm_req,
        output dm_we,
        output dm_addr,
        output dm_wstrb,
        output dm_wdata,
        input  dm_gnt,
        input  dm_rvalid,
        input  dm_rdata
    );

    modport slave (
        input  dm_req,
        input  dm_we,
        input  dm_addr,
        input  dm_wstrb,
        input  dm_wdata,
        output dm_gnt,
        output dm_rvalid,
        output dm_rdata
    );

endinterface

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage RV32 pipeline.
// Holds the EXE/MEM pipeline register, runs a request/grant/response access to
// data memory, aligns store data onto byte lanes, extracts and extends load data,
// and produces the forwarding value, the pipeline stall and the MEM/WB register.
// Byte-lane logic assumes DATA_WIDTH = 32.
module mem_access_stage #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,

    // EXE/MEM inputs
    input  logic                      EXE_MEM_MemRead,
    input  logic                      EXE_MEM_MemWrite,
    input  logic [2:0]                EXE_MEM_funct3,
    input  logic [REG_ADDR_WIDTH-1:0] EXE_MEM_rd_addr,
    input  logic                      EXE_MEM_gen_reg_write,
    input  logic                      EXE_MEM_fp_reg_write,
    input  logic                      EXE_MEM_WB_data_sel,
    input  logic [1:0]                EXE_MEM_MEM_rd_sel,
    input  logic [DATA_WIDTH-1:0]     ALU_out,
    input  logic [DATA_WIDTH-1:0]     PC_sel_out,
    input  logic [DATA_WIDTH-1:0]     EXE_mux_rs2_data,

    // Data-memory bus
    mem_access_stage_if.master        dm,

    // Hazard / forwarding
    output logic                      mem_stall,
    output logic [DATA_WIDTH-1:0]     MEM_rd_data,

    // MEM/WB outputs
    output logic [REG_ADDR_WIDTH-1:0] WB_rd_addr,
    output logic                      WB_gen_reg_write,
    output logic                      WB_fp_reg_write,
    output logic                      WB_WB_data_sel,
    output logic [DATA_WIDTH-1:0]     WB_rd_data,
    output logic [DATA_WIDTH-1:0]     WB_load_data,
    output logic                      WB_misalign_err
);

    typedef enum logic [0:0] {
        StIdle,
        StWait
    } state_e;

    state_e state_q;

    // EXE/MEM register fields
    logic                      mem_read_q;
    logic                      mem_write_q;
    logic [2:0]                funct3_q;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q;
    logic                      gen_we_q;
    logic                      fp_we_q;
    logic                      wb_sel_q;
    logic [1:0]                rd_sel_q;
    logic [DATA_WIDTH-1:0]     alu_q;
    logic [DATA_WIDTH-1:0]     pc_q;
    logic [DATA_WIDTH-1:0]     rs2_q;

    // Access classification
    logic       is_load;
    logic       is_store;
    logic       fault;
    logic       access;
    logic [1:0] byte_off;

    // Load extraction
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_ext;

    // ------------------------------------------------------------------------
    // EXE/MEM register: captures the EXE stage unless the stage is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            funct3_q    <= 3'b000;
            rd_addr_q   <= '0;
            gen_we_q    <= 1'b0;
            fp_we_q     <= 1'b0;
            wb_sel_q    <= 1'b0;
            rd_sel_q    <= 2'b00;
            alu_q       <= '0;
            pc_q        <= '0;
            rs2_q       <= '0;
        end else if (!mem_stall) begin
            mem_read_q  <= EXE_MEM_MemRead;
            mem_write_q <= EXE_MEM_MemWrite;
            funct3_q    <= EXE_MEM_funct3;
            rd_addr_q   <= EXE_MEM_rd_addr;
            gen_we_q    <= EXE_MEM_gen_reg_write;
            fp_we_q     <= EXE_MEM_fp_reg_write;
            wb_sel_q    <= EXE_MEM_WB_data_sel;
            rd_sel_q    <= EXE_MEM_MEM_rd_sel;
            alu_q       <= ALU_out;
            pc_q        <= PC_sel_out;
            rs2_q       <= EXE_mux_rs2_data;
        end
    end

    // MemRead wins when both read and write are flagged
    assign is_load  = mem_read_q;
    assign is_store = mem_write_q & ~mem_read_q;
    assign byte_off = alu_q[1:0];

    // Illegal size encodings and misaligned addresses fault before any request
    always_comb begin
        fault = 1'b0;
        if (is_load) begin
            case (funct3_q)
                3'b000, 3'b100: fault = 1'b0;
                3'b001, 3'b101: fault = byte_off[0];
                3'b010:         fault = |byte_off;
                default:        fault = 1'b1;
            endcase
        end else if (is_store) begin
            case (funct3_q)
                3'b000:  fault = 1'b0;
                3'b001:  fault = byte_off[0];
                3'b010:  fault = |byte_off;
                default: fault = 1'b1;
            endcase
        end
    end

    assign access = (is_load | is_store) & ~fault;

    // Forwarding value: only 01 picks the PC-derived value
    assign MEM_rd_data = (rd_sel_q == 2'b01) ? pc_q : alu_q;

    // ------------------------------------------------------------------------
    // Access FSM: a granted load waits for its response, a granted store is done
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (access && is_load && dm.dm_gnt) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (dm.dm_rvalid) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Request and stall: a store releases the pipeline in its grant cycle,
    // a load only once its response arrives
    always_comb begin
        dm.dm_req = 1'b0;
        mem_stall = 1'b0;
        case (state_q)
            StIdle: begin
                dm.dm_req = access;
                mem_stall = access & ~(is_store & dm.dm_gnt);
            end
            StWait: begin
                mem_stall = ~dm.dm_rvalid;
            end
            default: begin
                dm.dm_req = 1'b0;
                mem_stall = 1'b0;
            end
        endcase
    end

    assign dm.dm_we   = is_store;
    assign dm.dm_addr = {alu_q[DATA_WIDTH-1:2], 2'b00};

    // Store alignment: replicate the payload so every lane carries it, and
    // let the strobes pick which lanes are written
    always_comb begin
        dm.dm_wstrb = '0;
        dm.dm_wdata = rs2_q;
        if (is_store) begin
            case (funct3_q[1:0])
                2'b00: begin
                    dm.dm_wstrb = 4'b0001 << byte_off;
                    dm.dm_wdata = {4{rs2_q[7:0]}};
                end
                2'b01: begin
                    dm.dm_wstrb = byte_off[1] ? 4'b1100 : 4'b0011;
                    dm.dm_wdata = {2{rs2_q[15:0]}};
                end
                default: begin
                    dm.dm_wstrb = 4'b1111;
                    dm.dm_wdata = rs2_q;
                end
            endcase
        end
    end

    // Load extraction: pick the addressed byte/halfword, then extend
    always_comb begin
        case (byte_off)
            2'b00:   ld_byte = dm.dm_rdata[7:0];
            2'b01:   ld_byte = dm.dm_rdata[15:8];
            2'b10:   ld_byte = dm.dm_rdata[23:16];
            default: ld_byte = dm.dm_rdata[31:24];
        endcase
        ld_half = byte_off[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = dm.dm_rdata;
        endcase
    end

    // ------------------------------------------------------------------------
    // MEM/WB register: advances with the pipeline, takes a bubble while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            WB_rd_addr       <= '0;
            WB_gen_reg_write <= 1'b0;
            WB_fp_reg_write  <= 1'b0;
            WB_WB_data_sel   <= 1'b0;
            WB_rd_data       <= '0;
            WB_load_data     <= '0;
            WB_misalign_err  <= 1'b0;
        end else if (!mem_stall) begin
            WB_rd_addr       <= rd_addr_q;
            WB_gen_reg_write <= gen_we_q & ~fault;
            WB_fp_reg_write  <= fp_we_q & ~fault;
            WB_WB_data_sel   <= wb_sel_q;
            WB_rd_data       <= MEM_rd_data;
            WB_misalign_err  <= fault;
            // Unstalled in WAIT means the read response is here this cycle
            if (state_q == StWait) begin
                WB_load_data <= ld_ext;
            end
        end else begin
            WB_gen_reg_write <= 1'b0;
            WB_fp_reg_write  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases followed by random operations,
// with a memory responder that grants and answers after chosen delays.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        EXE_MEM_MemRead;
    logic        EXE_MEM_MemWrite;
    logic [2:0]  EXE_MEM_funct3;
    logic [4:0]  EXE_MEM_rd_addr;
    logic        EXE_MEM_gen_reg_write;
    logic        EXE_MEM_fp_reg_write;
    logic        EXE_MEM_WB_data_sel;
    logic [1:0]  EXE_MEM_MEM_rd_sel;
    logic [31:0] ALU_out;
    logic [31:0] PC_sel_out;
    logic [31:0] EXE_mux_rs2_data;
    logic        mem_stall;
    logic [31:0] MEM_rd_data;
    logic [4:0]  WB_rd_addr;
    logic        WB_gen_reg_write;
    logic        WB_fp_reg_write;
    logic        WB_WB_data_sel;
    logic [31:0] WB_rd_data;
    logic [31:0] WB_load_data;
    logic        WB_misalign_err;

    int tests = 0;
    int fails = 0;
    logic [4:0] prev_fill_rd;
    logic [4:0] next_fill_rd;

    always #5 clk = ~clk;

    mem_access_stage_if #(.DATA_WIDTH(32)) dm_bus ();

    mem_access_stage #(
        .DATA_WIDTH    (32),
        .REG_ADDR_WIDTH(5)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .EXE_MEM_MemRead      (EXE_MEM_MemRead),
        .EXE_MEM_MemWrite     (EXE_MEM_MemWrite),
        .EXE_MEM_funct3       (EXE_MEM_funct3),
        .EXE_MEM_rd_addr      (EXE_MEM_rd_addr),
        .EXE_MEM_gen_reg_write(EXE_MEM_gen_reg_write),
        .EXE_MEM_fp_reg_write (EXE_MEM_fp_reg_write),
        .EXE_MEM_WB_data_sel  (EXE_MEM_WB_data_sel),
        .EXE_MEM_MEM_rd_sel   (EXE_MEM_MEM_rd_sel),
        .ALU_out              (ALU_out),
        .PC_sel_out           (PC_sel_out),
        .EXE_mux_rs2_data     (EXE_mux_rs2_data),
        .dm                   (dm_bus),
        .mem_stall            (mem_stall),
        .MEM_rd_data          (MEM_rd_data),
        .WB_rd_addr           (WB_rd_addr),
        .WB_gen_reg_write     (WB_gen_reg_write),
        .WB_fp_reg_write      (WB_fp_reg_write),
        .WB_WB_data_sel       (WB_WB_data_sel),
        .WB_rd_data           (WB_rd_data),
        .WB_load_data         (WB_load_data),
        .WB_misalign_err      (WB_misalign_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_fault(input bit ld, input bit st, input logic [2:0] f3,
                                       input logic [31:0] a);
        int sz;
        bit legal;
        if (!ld && !st) return 1'b0;
        legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        if (!legal) return 1'b1;
        sz = 1 << int'(f3[1:0]);
        return (int'(a[1:0]) % sz) != 0;
    endfunction

    function automatic logic [31:0] model_wstrb(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        int mask;
        sz = 1 << int'(f3[1:0]);
        mask = (1 << sz) - 1;
        return 32'(mask << int'(a[1:0]));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1:0] == 2'd0) return 32'(d[7:0]) * 32'h0101_0101;
        if (f3[1:0] == 2'd1) return 32'(d[15:0]) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] w;
        logic [31:0] m;
        int bits;
        if (f3[1:0] == 2'd2) return rd;
        bits = 8 << int'(f3[1:0]);
        w = rd >> (int'(a[1:0]) * 8);
        m = (32'd1 << bits) - 32'd1;
        w = w & m;
        if (!f3[2] && w[bits-1]) w = w | ~m;
        return w;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive_zero();
        EXE_MEM_MemRead       = 1'b0;
        EXE_MEM_MemWrite      = 1'b0;
        EXE_MEM_funct3        = 3'd0;
        EXE_MEM_rd_addr       = 5'd0;
        EXE_MEM_gen_reg_write = 1'b0;
        EXE_MEM_fp_reg_write  = 1'b0;
        EXE_MEM_WB_data_sel   = 1'b0;
        EXE_MEM_MEM_rd_sel    = 2'd0;
        ALU_out               = 32'd0;
        PC_sel_out            = 32'd0;
        EXE_mux_rs2_data      = 32'd0;
        next_fill_rd          = 5'd0;
    endtask

    // Non-memory filler that always writes, so a later bubble is visible
    task automatic drive_fill();
        EXE_MEM_MemRead       = 1'b0;
        EXE_MEM_MemWrite      = 1'b0;
        EXE_MEM_funct3        = 3'($urandom);
        EXE_MEM_rd_addr       = 5'($urandom);
        EXE_MEM_gen_reg_write = 1'b1;
        EXE_MEM_fp_reg_write  = 1'($urandom);
        EXE_MEM_WB_data_sel   = 1'($urandom);
        EXE_MEM_MEM_rd_sel    = 2'($urandom);
        ALU_out               = $urandom;
        PC_sel_out            = $urandom;
        EXE_mux_rs2_data      = $urandom;
        next_fill_rd          = EXE_MEM_rd_addr;
    endtask

    task automatic run_op(input string tag, input bit ld, input bit st, input logic [2:0] f3,
                          input logic [4:0] rd, input bit gen, input bit fp, input bit wbsel,
                          input logic [1:0] rdsel, input logic [31:0] alu,
                          input logic [31:0] pc, input logic [31:0] rs2, input int gdelay,
                          input int rdelay, input logic [31:0] rdata);
        bit isld;
        bit isst;
        bit flt;
        bit acc;
        int stalls;
        logic [31:0] fwd;
        isld   = ld;
        isst   = st && !ld;
        flt    = model_fault(isld, isst, f3, alu);
        acc    = (isld || isst) && !flt;
        fwd    = (rdsel == 2'b01) ? pc : alu;
        stalls = 0;

        EXE_MEM_MemRead       = ld;
        EXE_MEM_MemWrite      = st;
        EXE_MEM_funct3        = f3;
        EXE_MEM_rd_addr       = rd;
        EXE_MEM_gen_reg_write = gen;
        EXE_MEM_fp_reg_write  = fp;
        EXE_MEM_WB_data_sel   = wbsel;
        EXE_MEM_MEM_rd_sel    = rdsel;
        ALU_out               = alu;
        PC_sel_out            = pc;
        EXE_mux_rs2_data      = rs2;
        dm_bus.dm_gnt         = 1'b0;
        dm_bus.dm_rvalid      = 1'b0;
        @(posedge clk);
        #1;
        drive_fill();

        if (!acc) begin
            @(negedge clk);
            check({tag, ".req"}, 32'(dm_bus.dm_req), 32'd0);
            check({tag, ".stall"}, 32'(mem_stall), 32'd0);
            check({tag, ".fwd"}, MEM_rd_data, fwd);
            @(posedge clk);
            #1;
        end else begin
            for (int k = 0; k <= gdelay; k++) begin
                dm_bus.dm_gnt = (k == gdelay);
                @(negedge clk);
                if (k == 0) check({tag, ".fwd"}, MEM_rd_data, fwd);
                check({tag, ".req"}, 32'(dm_bus.dm_req), 32'd1);
                check({tag, ".we"}, 32'(dm_bus.dm_we), 32'(isst));
                check({tag, ".addr"}, dm_bus.dm_addr, alu & 32'hFFFF_FFFC);
                if (isst) begin
                    check({tag, ".wstrb"}, 32'(dm_bus.dm_wstrb), model_wstrb(f3, alu));
                    check({tag, ".wdata"}, dm_bus.dm_wdata, model_wdata(f3, rs2));
                end
                check({tag, ".stall_g"}, 32'(mem_stall), (isst && k == gdelay) ? 32'd0 : 32'd1);
                if (k > 0) begin
                    check({tag, ".bubble_we"}, 32'({WB_gen_reg_write, WB_fp_reg_write}), 32'd0);
                    check({tag, ".bubble_rd"}, 32'(WB_rd_addr), 32'(prev_fill_rd));
                end
                if (mem_stall) stalls++;
                @(posedge clk);
                #1;
            end
            dm_bus.dm_gnt = 1'b0;
            if (isld) begin
                for (int k = 0; k <= rdelay; k++) begin
                    dm_bus.dm_rvalid = (k == rdelay);
                    dm_bus.dm_rdata  = (k == rdelay) ? rdata : $urandom;
                    @(negedge clk);
                    check({tag, ".req_w"}, 32'(dm_bus.dm_req), 32'd0);
                    check({tag, ".stall_w"}, 32'(mem_stall), (k == rdelay) ? 32'd0 : 32'd1);
                    check({tag, ".bubble_we"}, 32'({WB_gen_reg_write, WB_fp_reg_write}), 32'd0);
                    if (mem_stall) stalls++;
                    @(posedge clk);
                    #1;
                end
                dm_bus.dm_rvalid = 1'b0;
            end
            check({tag, ".stall_cnt"}, 32'(stalls), 32'(isst ? gdelay : gdelay + 1 + rdelay));
        end

        check({tag, ".wb_rd"}, 32'(WB_rd_addr), 32'(rd));
        check({tag, ".wb_gen"}, 32'(WB_gen_reg_write), 32'(gen && !flt));
        check({tag, ".wb_fp"}, 32'(WB_fp_reg_write), 32'(fp && !flt));
        check({tag, ".wb_sel"}, 32'(WB_WB_data_sel), 32'(wbsel));
        check({tag, ".wb_data"}, WB_rd_data, fwd);
        check({tag, ".wb_err"}, 32'(WB_misalign_err), 32'(flt));
        if (acc && isld) check({tag, ".wb_load"}, WB_load_data, model_load(f3, alu, rdata));
        prev_fill_rd = next_fill_rd;
    endtask

    // Safety net so the run always ends on its own
    initial begin
        #400000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        drive_zero();
        dm_bus.dm_gnt    = 1'b0;
        dm_bus.dm_rvalid = 1'b0;
        dm_bus.dm_rdata  = 32'd0;
        prev_fill_rd     = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst.req", 32'(dm_bus.dm_req), 32'd0);
        check("rst.stall", 32'(mem_stall), 32'd0);
        check("rst.fwd", MEM_rd_data, 32'd0);
        check("rst.wb", {WB_rd_data[25:0], WB_rd_addr, WB_gen_reg_write}, 32'd0);
        check("rst.wb2", 32'({WB_fp_reg_write, WB_WB_data_sel, WB_misalign_err}), 32'd0);
        check("rst.load", WB_load_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed cases
        run_op("fwd_pc", 0, 0, 3'd0, 5'd7, 1, 0, 1, 2'b01, 32'h0000_0888, 32'h0000_0104,
               32'd0, 0, 0, 32'd0);
        run_op("sb", 0, 1, 3'd0, 5'd0, 0, 0, 0, 2'b00, 32'h0000_1003, 32'd0, 32'h0000_00A5,
               1, 0, 32'd0);
        run_op("lb", 1, 0, 3'd0, 5'd9, 1, 0, 1, 2'b00, 32'h0000_2002, 32'd0, 32'd0, 0, 1,
               32'h12F0_5678);
        run_op("lhu", 1, 0, 3'd5, 5'd10, 1, 0, 1, 2'b00, 32'h0000_2002, 32'd0, 32'd0, 1, 0,
               32'h8001_0000);
        run_op("lw", 1, 0, 3'd2, 5'd11, 0, 1, 1, 2'b00, 32'h0000_2000, 32'd0, 32'd0, 2, 2,
               32'hCAFE_F00D);
        run_op("lw_mis", 1, 0, 3'd2, 5'd12, 1, 1, 1, 2'b00, 32'h0000_2006, 32'd0, 32'd0, 0, 0,
               32'd0);
        run_op("sh_hi", 0, 1, 3'd1, 5'd0, 0, 0, 0, 2'b10, 32'h0000_300E, 32'd0, 32'h1234_BEEF,
               0, 0, 32'd0);
        run_op("sw", 0, 1, 3'd2, 5'd0, 0, 0, 0, 2'b11, 32'h0000_3010, 32'd0, 32'h7654_3210,
               3, 0, 32'd0);
        run_op("ld_st", 1, 1, 3'd4, 5'd13, 1, 0, 1, 2'b00, 32'h0000_4003, 32'd0, 32'd0, 0, 0,
               32'h9A00_0000);

        // Reset while a load waits for its response; the late rvalid is ignored
        EXE_MEM_MemRead       = 1'b1;
        EXE_MEM_MemWrite      = 1'b0;
        EXE_MEM_funct3        = 3'd2;
        EXE_MEM_rd_addr       = 5'd3;
        EXE_MEM_gen_reg_write = 1'b1;
        ALU_out               = 32'h0000_5000;
        @(posedge clk);
        #1;
        drive_zero();
        dm_bus.dm_gnt = 1'b1;
        @(negedge clk);
        check("rstw.req", 32'(dm_bus.dm_req), 32'd1);
        @(posedge clk);
        #1;
        dm_bus.dm_gnt = 1'b0;
        @(negedge clk);
        check("rstw.wait", 32'(mem_stall), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        dm_bus.dm_rvalid = 1'b1;
        dm_bus.dm_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rstw.req0", 32'(dm_bus.dm_req), 32'd0);
        check("rstw.stall", 32'(mem_stall), 32'd0);
        check("rstw.fwd", MEM_rd_data, 32'd0);
        @(posedge clk);
        #1;
        dm_bus.dm_rvalid = 1'b0;
        check("rstw.load", WB_load_data, 32'd0);
        check("rstw.wb", {WB_rd_data[25:0], WB_rd_addr, WB_gen_reg_write}, 32'd0);
        check("rstw.wb2", 32'({WB_fp_reg_write, WB_WB_data_sel, WB_misalign_err}), 32'd0);
        @(negedge clk);
        check("rstw.idle", 32'(mem_stall), 32'd0);
        prev_fill_rd = 5'd0;

        // Random operations
        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = $urandom_range(0, 3);
            run_op("rnd", kind == 1 || kind == 3, kind == 2 || kind == 3, 3'($urandom),
                   5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                   $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
